// File: rtl/oxygen_pkg.sv
// Shared definitions for the oxygen display: state encoding, segment
// patterns and the oxygen counter's starting value.
package oxygen_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    WARN   = 2'd1,
    REFILL = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Starting digits of the oxygen counter; the display's previous-value
  // register resets to this so the initial load is not seen as a refill.
  localparam logic [3:0] STARTING_UPPER = 4'd2;
  localparam logic [3:0] STARTING_LOWER = 4'd5;
  localparam logic [6:0] PREV_RESET =
    ({3'b000, STARTING_UPPER} * 7'd10) + {3'b000, STARTING_LOWER};

  // Value substituted when either digit is not valid BCD.
  localparam logic [6:0] VALUE_INVALID = 7'd99;

  function automatic logic digits_valid(input logic [3:0] upper,
                                        input logic [3:0] lower);
    return (upper <= 4'd9) && (lower <= 4'd9);
  endfunction

  function automatic logic [6:0] bcd_value(input logic [3:0] upper,
                                           input logic [3:0] lower);
    if (!digits_valid(upper, lower)) begin
      return VALUE_INVALID;
    end
    return ({3'b000, upper} * 7'd10) + {3'b000, lower};
  endfunction

endpackage

// File: rtl/oxygen_display_if.sv
// Oxygen counter to display bus: two BCD digits and the game-over level.
// The counter side uses the master modport, the display the slave modport.
interface oxygen_display_if;
  logic [3:0] lowerDigit;
  logic [3:0] upperDigit;
  logic       gameOver;

  modport master (output lowerDigit, output upperDigit, output gameOver);
  modport slave  (input  lowerDigit, input  upperDigit, input  gameOver);
endinterface

// File: rtl/oxygen_display_bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern (bit0=a .. bit6=g).
// Codes above 9 display as a dash.
module bcd_to_seg7
  import oxygen_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup, no state.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/oxygen_display.sv
// Oxygen display: drives two active-low 7-segment digits and a warning LED
// from the oxygen counter bus, sequencing NORMAL / WARN / REFILL / OVER.
// Everything advances on the frame tick (fps), so timing is in frames.
// Optional build macro OXY_LEADING_BLANK_EN: blank the tens digit when it
// is zero in every digit-showing state (the OVER pattern is unaffected).
module oxygen_display
  import oxygen_pkg::*;
#(
  parameter int WARN_LEVEL        = 10,
  parameter int BLINK_FRAMES      = 15,
  parameter int REFILL_FRAMES     = 30,
  parameter int OVER_BLINK_FRAMES = 8
) (
  input  logic              fps,
  input  logic              resetn,
  oxygen_display_if.slave   cnt_if,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic              warnLED,
  output logic              refillPulse
);

  localparam logic [6:0] WARN_LVL   = 7'(WARN_LEVEL);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);
  localparam logic [5:0] REFILL_LAST = 6'(REFILL_FRAMES - 1);
  localparam logic [5:0] OVER_LAST  = 6'(OVER_BLINK_FRAMES - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic [6:0] prev_q, prev_d;
  logic [6:0] hex0_q, hex0_d;
  logic [6:0] hex1_q, hex1_d;
  logic       warn_q, warn_d;
  logic       pulse_q, pulse_d;

  logic [6:0] value;
  logic       valid;
  logic       refill_trig;
  logic       low;
  logic [6:0] seg_lower;
  logic [6:0] seg_upper;
  logic [6:0] hex1_shown;

  bcd_to_seg7 u_seg_lower (.bcd_i(cnt_if.lowerDigit), .seg_o(seg_lower));
  bcd_to_seg7 u_seg_upper (.bcd_i(cnt_if.upperDigit), .seg_o(seg_upper));

  // Decode the digits into a value and the two mode triggers. Invalid digits
  // read as 99, which never warns, and are barred from raising a refill.
  always_comb begin
    value       = bcd_value(cnt_if.upperDigit, cnt_if.lowerDigit);
    valid       = digits_valid(cnt_if.upperDigit, cnt_if.lowerDigit);
    refill_trig = valid && (value > prev_q);
    low         = value < WARN_LVL;
  end

  // Tens-digit pattern for digit-showing states, with optional leading blank.
  always_comb begin
`ifdef OXY_LEADING_BLANK_EN
    hex1_shown = (cnt_if.upperDigit == 4'd0) ? SEG_BLANK : seg_upper;
`else
    hex1_shown = seg_upper;
`endif
  end

  // Next state, frame counter and blink phase; priority gameOver > refill > warn.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    prev_d  = (state_q == OVER) ? prev_q : value;
    case (state_q)
      NORMAL: begin
        if (cnt_if.gameOver) begin
          state_d = OVER;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (refill_trig) begin
          state_d = REFILL;
          cnt_d   = '0;
        end else if (low) begin
          state_d = WARN;
          cnt_d   = '0;
          phase_d = 1'b1;
        end
      end
      WARN: begin
        if (cnt_if.gameOver) begin
          state_d = OVER;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (refill_trig) begin
          state_d = REFILL;
          cnt_d   = '0;
        end else if (!low) begin
          state_d = NORMAL;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (cnt_q == BLINK_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      REFILL: begin
        if (cnt_if.gameOver) begin
          state_d = OVER;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (refill_trig) begin
          cnt_d = '0;
        end else if (cnt_q == REFILL_LAST) begin
          state_d = low ? WARN : NORMAL;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      OVER: begin
        if (cnt_q == OVER_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = NORMAL;
        cnt_d   = '0;
        phase_d = 1'b1;
      end
    endcase
  end

  // Output patterns for the upcoming frame, taken from the next state.
  always_comb begin
    hex0_d  = SEG_BLANK;
    hex1_d  = SEG_BLANK;
    warn_d  = 1'b0;
    pulse_d = (state_d == REFILL) && (state_q != REFILL);
    case (state_d)
      NORMAL, REFILL: begin
        hex0_d = seg_lower;
        hex1_d = hex1_shown;
      end
      WARN: begin
        hex0_d = phase_d ? seg_lower  : SEG_BLANK;
        hex1_d = phase_d ? hex1_shown : SEG_BLANK;
        warn_d = phase_d;
      end
      OVER: begin
        hex0_d = phase_d ? SEG_DASH : SEG_BLANK;
        hex1_d = phase_d ? SEG_DASH : SEG_BLANK;
        warn_d = phase_d;
      end
      default: begin
        hex0_d = SEG_BLANK;
        hex1_d = SEG_BLANK;
      end
    endcase
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge fps or negedge resetn) begin
    if (!resetn) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      prev_q  <= PREV_RESET;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      warn_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      prev_q  <= prev_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      warn_q  <= warn_d;
      pulse_q <= pulse_d;
    end
  end

  assign HEX0        = hex0_q;
  assign HEX1        = hex1_q;
  assign warnLED     = warn_q;
  assign refillPulse = pulse_q;

endmodule

// File: tb/tb_oxygen_display.sv
// Directed bench for oxygen_display with hand-computed segment patterns.
module tb_oxygen_display;

  logic       fps = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic       warnLED;
  logic       refillPulse;

  int n_chk  = 0;
  int n_pass = 0;

  oxygen_display_if bus ();

  oxygen_display #(
    .WARN_LEVEL(10),
    .BLINK_FRAMES(15),
    .REFILL_FRAMES(30),
    .OVER_BLINK_FRAMES(8)
  ) dut (
    .fps(fps),
    .resetn(resetn),
    .cnt_if(bus),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .warnLED(warnLED),
    .refillPulse(refillPulse)
  );

  always #5 fps = ~fps;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic frame();
    @(posedge fps);
    #1;
  endtask

  task automatic set_digits(input int u, input int l);
    bus.upperDigit = 4'(u);
    bus.lowerDigit = 4'(l);
  endtask

  function automatic int seg(input int d);
    case (d)
      0: return 'h40;
      1: return 'h79;
      2: return 'h24;
      3: return 'h30;
      4: return 'h19;
      5: return 'h12;
      6: return 'h02;
      7: return 'h78;
      8: return 'h00;
      9: return 'h10;
      default: return 'h3F;
    endcase
  endfunction

  // Expected tens pattern when digits are being shown.
  function automatic int hex1_exp(input int u);
`ifdef OXY_LEADING_BLANK_EN
    if (u == 0) return 'h7F;
`endif
    return seg(u);
  endfunction

  initial begin
    bool_ph_decl: begin
      bit ph;
      bus.gameOver = 1'b0;
      set_digits(2, 5);
      repeat (2) frame();
      chk("reset_hex0", HEX0, 'h7F);
      chk("reset_hex1", HEX1, 'h7F);
      chk("reset_warn", warnLED, 0);
      chk("reset_pulse", refillPulse, 0);

      #3 resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
        frame();
        chk("start_hex1", HEX1, 'h24);
        chk("start_hex0", HEX0, 'h12);
        chk("start_warn", warnLED, 0);
        chk("start_pulse", refillPulse, 0);
      end

      // 10 is exactly the warning level: still NORMAL
      set_digits(1, 0);
      frame();
      chk("ten_hex1", HEX1, 'h79);
      chk("ten_hex0", HEX0, 'h40);
      chk("ten_warn", warnLED, 0);

      // 09 enters WARN: 15 frames lit, 15 blank, repeating
      set_digits(0, 9);
      for (int k = 0; k < 45; k++) begin
        frame();
        ph = ((k / 15) % 2) == 0;
        chk("warn_hex0", HEX0, ph ? 'h10 : 'h7F);
        chk("warn_hex1", HEX1, ph ? hex1_exp(0) : 'h7F);
        chk("warn_led", warnLED, int'(ph));
        chk("warn_pulse", refillPulse, 0);
      end
      set_digits(0, 5);
      frame();
      chk("warn_wrap_hex0", HEX0, 'h7F);
      chk("warn_wrap_led", warnLED, 0);

      // Jump to 25: refill for exactly 30 frames, single pulse
      set_digits(2, 5);
      frame();
      chk("refill_pulse", refillPulse, 1);
      chk("refill_hex1", HEX1, 'h24);
      chk("refill_hex0", HEX0, 'h12);
      chk("refill_led", warnLED, 0);
      for (int k = 1; k < 29; k++) begin
        frame();
        chk("refill_hold_pulse", refillPulse, 0);
        chk("refill_hold_hex0", HEX0, 'h12);
        chk("refill_hold_led", warnLED, 0);
      end
      set_digits(0, 5);
      frame();
      chk("refill_last_hex0", HEX0, 'h12);
      chk("refill_last_hex1", HEX1, hex1_exp(0));
      chk("refill_last_led", warnLED, 0);
      frame();
      chk("refill_exit_led", warnLED, 1);
      chk("refill_exit_hex0", HEX0, 'h12);

      // gameOver with a rising value in the same frame: OVER wins, no pulse
      bus.gameOver = 1'b1;
      set_digits(2, 5);
      for (int k = 0; k < 24; k++) begin
        frame();
        ph = ((k / 8) % 2) == 0;
        chk("over_hex0", HEX0, ph ? 'h3F : 'h7F);
        chk("over_hex1", HEX1, ph ? 'h3F : 'h7F);
        chk("over_led", warnLED, int'(ph));
        chk("over_pulse", refillPulse, 0);
        if (k == 3) begin
          bus.gameOver = 1'b0;
          set_digits(0, 1);
        end
      end

      // Asynchronous reset while dashes are lit
      #2 resetn = 1'b0;
      #1;
      chk("async_hex0", HEX0, 'h7F);
      chk("async_hex1", HEX1, 'h7F);
      chk("async_led", warnLED, 0);
      set_digits(2, 5);
      #1 resetn = 1'b1;
      frame();
      chk("post_reset_hex1", HEX1, 'h24);
      chk("post_reset_hex0", HEX0, 'h12);
      chk("post_reset_pulse", refillPulse, 0);

      // Invalid ones digit: dash, no warning, no refill
      set_digits(0, 12);
      frame();
      chk("invalid_hex0", HEX0, 'h3F);
      chk("invalid_hex1", HEX1, hex1_exp(0));
      chk("invalid_led", warnLED, 0);
      chk("invalid_pulse", refillPulse, 0);
      frame();
      chk("invalid_led2", warnLED, 0);

      set_digits(0, 7);
      frame();
      chk("seven_led", warnLED, 1);
      chk("seven_hex0", HEX0, 'h78);
      chk("seven_hex1", HEX1, hex1_exp(0));

      set_digits(3, 0);
      frame();
      chk("thirty_pulse", refillPulse, 1);
      chk("thirty_hex1", HEX1, 'h30);
      chk("thirty_hex0", HEX0, 'h40);
      frame();
      chk("thirty_pulse_once", refillPulse, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oxygen_display.md
Name: oxygen_display

Overview:
- Consumer end of the oxygen counter interface: takes the two BCD oxygen digits and the gameOver flag, and drives two active-low 7-segment displays plus a warning LED.
- Sequences four visual modes:
  - solid display (normal)
  - blinking display (low oxygen)
  - refill acknowledge flash (oxygen rose)
  - sticky game-over pattern
- Runs on the frame tick, so all timing is counted in frames.

Parameters:
- WARN_LEVEL, 10, decimal oxygen value strictly below which WARN mode is entered (range 0-99).
- BLINK_FRAMES, 15, frames per blink half-period in WARN (1-63).
- REFILL_FRAMES, 30, frames the REFILL mode is held after an oxygen increase (1-63).
- OVER_BLINK_FRAMES, 8, frames per blink half-period in OVER (1-63).

Ports:
- fps, input, 1, frame-rate clock; all state changes on its rising edge.
- resetn, input, 1, asynchronous active-low reset.
- lowerDigit, input, 4, BCD ones digit of oxygen.
- upperDigit, input, 4, BCD tens digit of oxygen.
- gameOver, input, 1, level; high means game ended.
- HEX0, output, 7, ones-digit segments, active-low, bit0=a … bit6=g.
- HEX1, output, 7, tens-digit segments, active-low.
- warnLED, output, 1, high while the warning blink phase is lit.
- refillPulse, output, 1, one-frame pulse on entering REFILL.

Behaviour:
- Clock and reset: one clock (fps); reset is asynchronous and active-low (resetn).
- Reset values:
  - state=NORMAL, blink counter=0, phase=1.
  - prevValue=7'd25.
  - HEX0=HEX1=7'h7F (blank).
  - warnLED=0, refillPulse=0.
- Value arithmetic:
  - value = upperDigit*10 + lowerDigit, 7 bits, no overflow for valid BCD.
  - A digit >9 is invalid: it displays as dash 7'h3F, and value is treated as 99 (no WARN, no REFILL).
- prevValue is registered every frame (except in OVER). REFILL trigger is value > prevValue.
- All outputs are registered: a one-frame latency from input to HEX/LED.
- States (priority when several triggers occur in the same frame: gameOver > refill > warn):
  - NORMAL:
    - HEX shows the digits solid; warnLED=0.
    - gameOver → OVER.
    - Refill trigger → REFILL.
    - value < WARN_LEVEL → WARN (counter cleared, phase=1).
  - WARN:
    - Counter increments each frame. At BLINK_FRAMES-1 it wraps to 0 and phase toggles.
    - phase=1: digits shown, warnLED=1. phase=0: both HEX blank, warnLED=0.
    - gameOver → OVER.
    - Refill trigger → REFILL.
    - value ≥ WARN_LEVEL → NORMAL.
  - REFILL:
    - Digits shown solid; warnLED=0.
    - refillPulse=1 only on the entry frame.
    - Counter runs to REFILL_FRAMES-1, then → NORMAL or WARN by the value compare.
    - A new refill trigger during REFILL restarts the counter with no new pulse.
    - gameOver → OVER.
  - OVER:
    - HEX0=HEX1=dash, blinking with OVER_BLINK_FRAMES half-period (blank on phase 0).
    - warnLED follows phase.
    - Sticky: exits only via resetn; ignores digits and gameOver deassert.
- Boundaries:
  - value == WARN_LEVEL is NORMAL.
  - value 0 without gameOver stays WARN.
  - Blink counter wrap is exact: half-period is exactly N frames.
  - Reset mid-state returns immediately (asynchronously) to reset values.
  - The first frame after reset compares against prevValue=25, so the starting load of 25 produces no refill.

Optional Feature:
- Macro OXY_LEADING_BLANK_EN.
- Defined: HEX1 is blank (7'h7F) whenever upperDigit==0 in any state that shows digits. The OVER pattern is unaffected.
- Undefined: a leading zero shows as "0".

Decomposition:
- Package oxygen_pkg holds:
  - the state enum {NORMAL, WARN, REFILL, OVER}, 2 bits
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F
  - the startingUpper/startingLower constants (2, 5) shared with the oxygen counter, from which prevValue's reset value is derived.
- Sub-module bcd_to_seg7 (4-bit BCD in, 7-bit active-low out, invalid → SEG_DASH), instantiated twice. The FSM, counters and output registers stay in the top.

Test Plan:
- Reset then digits 2/5 → after 1 frame HEX1=7'h24 ("2"), HEX0=7'h12 ("5"), warnLED=0, refillPulse never 1.
- Digits step down from 10 to 09 → WARN. HEX shows "09" for 15 frames, blank for 15 frames, and so on; warnLED toggles with the same period.
- In WARN at 05, digits jump to 25 → refillPulse high for exactly 1 frame. Solid "25" for 30 frames, then NORMAL.
- gameOver asserted while the value is rising in the same frame → OVER (no refillPulse). Dashes blink at 8-frame half-period and persist after gameOver=0 until resetn.
- lowerDigit=4'hC → HEX0=7'h3F and no WARN entry. With OXY_LEADING_BLANK_EN and digits 0/7 → HEX1=7'h7F.
- resetn pulsed low mid-WARN blink (phase 0) → outputs blank immediately, then NORMAL solid display on the next frame.
